// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if
//   APB bus bundle between the team's APB master and the apb_slave_mem
//   completer. PCLK and PRESETn are not part of the bundle; they are plain
//   ports on the modules that use it.
//
//   Signals:
//     PSEL, PENABLE, PWRITE, PADDR, PWDATA  master -> completer
//     PRDATA, PREADY, PSLVERR               completer -> master
//
//   Modports: master, slave.
interface apb_slave_mem_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB completer backed by a DEPTH-entry register memory. Inserts
//   WAIT_CYCLES wait states before PREADY and answers out-of-range
//   addresses (PADDR >= DEPTH) with PSLVERR. It is the only slave on the
//   bus, so PSEL is used directly as the select.
//
//   Ports:
//     PCLK      in   clock, rising edge
//     PRESETn   in   asynchronous active-low reset; also clears the memory
//     apb       slave modport of apb_slave_mem_if
//                 PSEL/PENABLE/PWRITE/PADDR/PWDATA in
//                 PRDATA/PREADY/PSLVERR out, all registered
//
//   Build option:
//     APB_SLV_WAIT_STATES_EN  defined   : WAIT_CYCLES (0..15) wait states
//                             undefined : WAIT state and counter are not
//                                         built, every transfer is zero-wait
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transfer in progress, outputs low
//   ST_WAIT  | setup seen, counting down wait states (wait-state build only)
//   ST_READY | PREADY high, PRDATA/PSLVERR valid, waiting for completion
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   apb_slave_mem_if.slave   apb
);

   localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [3:0]          WAIT_L  = 4'(WAIT_CYCLES);

`ifdef APB_SLV_WAIT_STATES_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_READY = 1'b1
   } state_t;
`endif

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       addr_q, addr_d;
   logic                   write_q, write_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
`ifdef APB_SLV_WAIT_STATES_EN
   logic [3:0]             cnt_q, cnt_d;
`else
   logic                   unused_wait_cycles;
   assign unused_wait_cycles = ^WAIT_L;
`endif

   logic setup;
   logic access;
   logic enter_ready;

   // A setup phase is recognised in every state so that a new transfer
   // always wins over whatever was in flight.
   assign setup  = apb.PSEL & ~apb.PENABLE;
   assign access = apb.PSEL &  apb.PENABLE;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      prdata_d    = prdata_q;
      pready_d    = pready_q;
      pslverr_d   = pslverr_q;
      mem_d       = mem_q;
      enter_ready = 1'b0;
`ifdef APB_SLV_WAIT_STATES_EN
      cnt_d       = cnt_q;
`endif

      if (setup) begin
         addr_d    = apb.PADDR[IDX_W-1:0];
         write_d   = apb.PWRITE;
         wdata_d   = apb.PWDATA;
         err_d     = ({1'b0, apb.PADDR} >= DEPTH_L);
         pready_d  = 1'b0;
         pslverr_d = 1'b0;
         prdata_d  = '0;
`ifdef APB_SLV_WAIT_STATES_EN
         if (WAIT_L == 4'd0) begin
            state_d     = ST_READY;
            enter_ready = 1'b1;
            cnt_d       = 4'd0;
         end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_L;
         end
`else
         state_d     = ST_READY;
         enter_ready = 1'b1;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
            end
`ifdef APB_SLV_WAIT_STATES_EN
            ST_WAIT: begin
               if (!apb.PSEL) begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
               end else if (access) begin
                  cnt_d = cnt_q - 4'd1;
                  // Leaving on the edge where the count hits zero makes
                  // PREADY rise exactly WAIT_CYCLES edges after setup.
                  if (cnt_q <= 4'd1) begin
                     cnt_d       = 4'd0;
                     state_d     = ST_READY;
                     enter_ready = 1'b1;
                  end
               end
            end
`endif
            ST_READY: begin
               if (!apb.PSEL || access) begin
                  if (access && write_q && !err_q) begin
                     mem_d[addr_q] = wdata_q;
                  end
                  state_d   = ST_IDLE;
                  pready_d  = 1'b0;
                  pslverr_d = 1'b0;
                  prdata_d  = '0;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end
         endcase
      end

      // Read data is sampled from the array on READY entry, using the
      // address being captured this edge when setup goes straight to READY.
      if (enter_ready) begin
         pready_d  = 1'b1;
         pslverr_d = err_d;
         prdata_d  = (!write_d && !err_d) ? mem_q[addr_d] : '0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_STATES_EN
         cnt_q     <= 4'd0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_STATES_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign apb.PRDATA  = prdata_q;
   assign apb.PREADY  = pready_q;
   assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem
//   Directed bench for apb_slave_mem. A transaction-level model (memory
//   array plus the latency rule "PREADY after WAIT edges, completion one
//   edge later") sets the expected outputs for every cycle; one process
//   compares them on each falling edge. A few literal expectations pin
//   the read data, error flag and PREADY latency.
module tb_apb_slave_mem;

   localparam int AW    = 8;
   localparam int DW    = 8;
   localparam int DEPTH = 64;
`ifdef APB_SLV_WAIT_STATES_EN
   localparam int WC    = 1;
   localparam int W_EFF = 1;
`else
   localparam int WC    = 3;
   localparam int W_EFF = 0;
`endif

   logic pclk = 1'b0;
   logic presetn;
   always #5 pclk = ~pclk;

   apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_slave_mem #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .WAIT_CYCLES(WC)
   ) dut (
      .PCLK   (pclk),
      .PRESETn(presetn),
      .apb    (apb)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic        chk_en      = 1'b0;
   logic        exp_pready  = 1'b0;
   logic        exp_pslverr = 1'b0;
   logic [7:0]  exp_prdata  = 8'h00;
   logic [7:0]  mem_m [DEPTH];

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge pclk) begin
      if (chk_en) begin
         chk1("cyc_pready",  apb.PREADY,  exp_pready);
         chk1("cyc_pslverr", apb.PSLVERR, exp_pslverr);
         chk8("cyc_prdata",  apb.PRDATA,  exp_prdata);
      end
   end

   task automatic set_exp_idle();
      exp_pready  = 1'b0;
      exp_pslverr = 1'b0;
      exp_prdata  = 8'h00;
   endtask

   task automatic idle_cycle();
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      @(posedge pclk); #1;
      set_exp_idle();
   endtask

   // mode 0: normal transfer, 1: drop PSEL after the setup edge,
   // 2: leave after the setup edge so the caller issues a new setup,
   // 3: assert reset while PREADY is expected high.
   task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input int mode, output logic [7:0] rd, output logic er,
                       output int rise);
      logic e;
      e    = (a >= DEPTH);
      rd   = 8'h00;
      er   = 1'b0;
      rise = -1;
      apb.PSEL    = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = wr;
      apb.PADDR   = a;
      apb.PWDATA  = d;
      @(posedge pclk); #1;
      for (int j = 0; j <= W_EFF; j++) begin
         if (j >= W_EFF) begin
            exp_pready  = 1'b1;
            exp_pslverr = e;
            exp_prdata  = (!wr && !e) ? mem_m[a[5:0]] : 8'h00;
         end else begin
            set_exp_idle();
         end
         if (rise < 0 && apb.PREADY === 1'b1) rise = j;
         if (j == W_EFF) begin
            rd = apb.PRDATA;
            er = apb.PSLVERR;
         end
         if (mode == 2) return;
         if (mode == 1) begin
            apb.PSEL = 1'b0;
            @(posedge pclk); #1;
            set_exp_idle();
            return;
         end
         if (mode == 3 && j == W_EFF) begin
            #1;
            presetn = 1'b0;
            #1;
            chk1("rst_mid_pready",  apb.PREADY,  1'b0);
            chk1("rst_mid_pslverr", apb.PSLVERR, 1'b0);
            chk8("rst_mid_prdata",  apb.PRDATA,  8'h00);
            for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
            set_exp_idle();
            apb.PSEL    = 1'b0;
            apb.PENABLE = 1'b0;
            return;
         end
         apb.PENABLE = 1'b1;
         @(posedge pclk); #1;
      end
      if (wr && !e) mem_m[a[5:0]] = d;
      set_exp_idle();
   endtask

   logic [7:0] rd;
   logic       er;
   int         rise;

   initial begin
      presetn     = 1'b0;
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = 8'h00;
      apb.PWDATA  = 8'h00;
      for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
      #1 chk_en = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      chk1("reset_pready",  apb.PREADY,  1'b0);
      chk1("reset_pslverr", apb.PSLVERR, 1'b0);
      chk8("reset_prdata",  apb.PRDATA,  8'h00);
      @(negedge pclk);
      presetn = 1'b1;
      idle_cycle();

      // write then read back
      xfer(1'b1, 8'h10, 8'hA5, 0, rd, er, rise);
      chk_int("wr_latency", rise, W_EFF);
      idle_cycle();
      xfer(1'b0, 8'h10, 8'h00, 0, rd, er, rise);
      chk8("rd_0x10", rd, 8'hA5);
      chk1("rd_0x10_err", er, 1'b0);
      chk_int("rd_latency", rise, W_EFF);
      idle_cycle();

      // last valid entry and first invalid address
      xfer(1'b1, 8'h3F, 8'hC3, 0, rd, er, rise);
      xfer(1'b0, 8'h3F, 8'h00, 0, rd, er, rise);
      chk8("rd_0x3f", rd, 8'hC3);
      idle_cycle();
      xfer(1'b1, 8'h40, 8'h3C, 0, rd, er, rise);
      chk1("wr_0x40_err", er, 1'b1);
      idle_cycle();
      xfer(1'b0, 8'h40, 8'h00, 0, rd, er, rise);
      chk1("rd_0x40_err", er, 1'b1);
      chk8("rd_0x40", rd, 8'h00);
      xfer(1'b0, 8'h00, 8'h00, 0, rd, er, rise);
      chk8("rd_0x00_no_alias", rd, 8'h00);
      xfer(1'b0, 8'hFF, 8'h00, 0, rd, er, rise);
      chk1("rd_0xff_err", er, 1'b1);
      idle_cycle();

      // back-to-back, no idle cycles
      xfer(1'b1, 8'h01, 8'h11, 0, rd, er, rise);
      xfer(1'b1, 8'h02, 8'h22, 0, rd, er, rise);
      xfer(1'b0, 8'h01, 8'h00, 0, rd, er, rise);
      chk8("b2b_rd_0x01", rd, 8'h11);
      xfer(1'b0, 8'h02, 8'h00, 0, rd, er, rise);
      chk8("b2b_rd_0x02", rd, 8'h22);
      idle_cycle();

      // abort after setup: nothing committed
      xfer(1'b1, 8'h03, 8'h77, 1, rd, er, rise);
      idle_cycle();
      xfer(1'b0, 8'h03, 8'h00, 0, rd, er, rise);
      chk8("abort_rd_0x03", rd, 8'h00);
      idle_cycle();

      // new setup while a write is in flight drops the write
      xfer(1'b1, 8'h04, 8'h99, 2, rd, er, rise);
      xfer(1'b0, 8'h04, 8'h00, 0, rd, er, rise);
      chk8("restart_rd_0x04", rd, 8'h00);
      xfer(1'b1, 8'h04, 8'h5C, 0, rd, er, rise);
      xfer(1'b0, 8'h04, 8'h00, 0, rd, er, rise);
      chk8("rd_0x04_after", rd, 8'h5C);
      idle_cycle();

      // reset in the middle of a read clears outputs and memory
      xfer(1'b1, 8'h05, 8'h5A, 0, rd, er, rise);
      xfer(1'b0, 8'h05, 8'h00, 3, rd, er, rise);
      chk8("pre_rst_rd_0x05", rd, 8'h5A);
      @(negedge pclk);
      presetn = 1'b1;
      idle_cycle();
      xfer(1'b0, 8'h05, 8'h00, 0, rd, er, rise);
      chk8("post_rst_rd_0x05", rd, 8'h00);
      xfer(1'b0, 8'h10, 8'h00, 0, rd, er, rise);
      chk8("post_rst_rd_0x10", rd, 8'h00);
      idle_cycle();
      idle_cycle();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
